// File: rtl/pair_det_sched.sv
// Round-robin scheduler that time-shares one serial pair-of-ones detector among N_REQ requesters.
// Each granted frame is cleared, primed, shifted LSB-first into the detector and its pulses counted.
module pair_det_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned CNT_W   = $clog2(FRAME_W / 2 + 1),
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*FRAME_W-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       det_rst,
    output logic                       det_din,
    input  logic                       det_dout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [CNT_W-1:0]           rsp_count,
    output logic                       err
);

    localparam int unsigned BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClr   = 3'd1;
    localparam logic [2:0] StPrime = 3'd2;
    localparam logic [2:0] StShift = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]         st_q, st_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               det_rst_q, det_rst_d;
    logic               det_din_q, det_din_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;
    logic               err_q, err_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               hs;
    logic [FRAME_W-1:0] sel_data;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((32'(last_q) + i) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant is gated by rst so req_ready reads 0 while reset is held.
    assign hs = (st_q == StIdle) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_data = req_data[32'(grant_idx) * FRAME_W +: FRAME_W];

    always_comb begin
        st_d        = st_q;
        last_d      = last_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        det_rst_d   = det_rst_q;
        det_din_d   = det_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;

        unique case (st_q)
            StIdle: begin
                if (hs) begin
                    st_d        = StClr;
                    sh_d        = sel_data;
                    rsp_id_d    = grant_idx;
                    last_d      = grant_idx;
                    rsp_count_d = '0;
                    det_rst_d   = 1'b1;
                    det_din_d   = 1'b0;
                end
            end
            StClr: begin
                st_d      = StPrime;
                det_rst_d = 1'b0;
                det_din_d = 1'b0;
            end
            StPrime: begin
                // Present bit 0 for the first SHIFT cycle.
                st_d      = StShift;
                det_din_d = sh_q[0];
                sh_d      = sh_q >> 1;
                bit_d     = '0;
            end
            StShift: begin
                if (det_dout && (rsp_count_q != CNT_MAX)) begin
                    rsp_count_d = rsp_count_q + 1'b1;
                end
                if (bit_q == LAST_BIT) begin
                    st_d        = StResp;
                    det_din_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    bit_d     = bit_q + 1'b1;
                    det_din_d = sh_q[0];
                    sh_d      = sh_q >> 1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    st_d        = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                st_d = StIdle;
            end
        endcase
    end

    // A detector pulse is only legitimate while a frame bit is being presented.
    assign err_d = err_q | (det_dout & (st_q != StShift));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= StIdle;
            last_q      <= LAST_RST;
            sh_q        <= '0;
            bit_q       <= '0;
            det_rst_q   <= 1'b1;
            det_din_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            last_q      <= last_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            det_rst_q   <= det_rst_d;
            det_din_q   <= det_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            err_q       <= err_d;
        end
    end

    assign det_rst   = det_rst_q;
    assign det_din   = det_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pair_det_sched.sv
// Randomized bench for pair_det_sched with a pair-of-ones detector model and a
// transaction-level reference (round-robin order, floor(popcount/2) counts, fixed latency).
module tb_pair_det_sched;

    localparam int NR = 4;
    localparam int FW = 8;
    localparam int CW = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*FW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              det_rst;
    logic              det_din;
    logic              det_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [CW-1:0]     rsp_count;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last;
    bit exp_err;
    bit inj = 1'b0;
    logic [1:0] dst = 2'd0;  // 0 idle, 1 s0, 2 s1 (one 1 seen)

    pair_det_sched #(.N_REQ(NR), .FRAME_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_rst   (det_rst),
        .det_din   (det_din),
        .det_dout  (det_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Pair-of-ones detector: pulses (Mealy) on every second 1 after leaving idle.
    always @(posedge clk) begin
        if (det_rst) dst <= 2'd0;
        else if (dst == 2'd0) dst <= 2'd1;
        else if (det_din) dst <= (dst == 2'd1) ? 2'd2 : 2'd1;
    end
    assign det_dout = ((dst == 2'd2) && det_din) || inj;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_req(input int i, input logic [FW-1:0] d);
        req_valid[i] = 1'b1;
        req_data[i*FW +: FW] = d;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_det_rst", det_rst, 1);
        check_eq("rst_det_din", det_din, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_count", rsp_count, 0);
        check_eq("rst_err", err, 0);
    endtask

    // Called at a negedge with the DUT idle and at least one request valid.
    task automatic run_frame(input int rst_at, input bit inj_prime, input int bp);
        int g;
        int c;
        int exp_cnt;
        logic [FW-1:0] fr;
        #1;
        g = -1;
        for (int i = 1; i <= NR; i++) begin
            c = (m_last + i) % NR;
            if (g < 0 && req_valid[c]) g = c;
        end
        if (g < 0) begin
            check_eq("no_request", req_ready, 0);
            return;
        end
        check_eq("grant", req_ready, 64'(1) << g);
        fr = req_data[g*FW +: FW];
        exp_cnt = $countones(fr) / 2;
        @(posedge clk);
        m_last = g;
        #1;
        req_valid[g] = 1'b0;
        for (int j = 0; j < FW + 2; j++) begin
            @(negedge clk);
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset_vals();
                @(negedge clk);
                rst = 1'b0;
                m_last = NR - 1;
                exp_err = 1'b0;
                return;
            end
            if (inj_prime && j == 2) begin
                inj = 1'b0;
                exp_err = 1'b1;
            end
            check_eq("busy_ready", req_ready, 0);
            check_eq("early_rsp_valid", rsp_valid, 0);
            check_eq("det_rst", det_rst, (j == 0) ? 1 : 0);
            check_eq("det_din", det_din, (j >= 2) ? fr[j-2] : 1'b0);
            check_eq("err", err, exp_err);
            if (inj_prime && j == 1) inj = 1'b1;
        end
        @(negedge clk);
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_id", rsp_id, g);
        check_eq("rsp_count", rsp_count, exp_cnt);
        check_eq("rsp_err", err, exp_err);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_id", rsp_id, g);
            check_eq("hold_count", rsp_count, exp_cnt);
            check_eq("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        m_last = NR - 1;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        add_req(0, 8'hFF);
        run_frame(-1, 0, 0);
        add_req(1, 8'h55);
        run_frame(-1, 0, 1);
        add_req(1, 8'h01);
        run_frame(-1, 0, 0);
        add_req(1, 8'h00);
        run_frame(-1, 0, 0);

        // Two requesters that re-request after every grant.
        add_req(0, 8'hA3);
        add_req(2, 8'h3C);
        for (int r = 0; r < 4; r++) begin
            run_frame(-1, 0, 0);
            if (!req_valid[0]) add_req(0, 8'($urandom));
            if (!req_valid[2]) add_req(2, 8'($urandom));
        end
        req_valid = '0;

        add_req(3, 8'hB7);
        run_frame(-1, 0, 5);

        // Reset in the third SHIFT cycle with another request still pending.
        add_req(1, 8'hFF);
        add_req(2, 8'h77);
        run_frame(4, 0, 0);
        req_valid = '0;
        add_req(2, 8'h0F);
        run_frame(-1, 0, 0);

        add_req(1, 8'hE1);
        run_frame(-1, 1, 0);
        add_req(0, 8'h99);
        run_frame(-1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) add_req(i, 8'($urandom));
                else if (req_valid[i] && $urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end
            if (req_valid == '0) add_req($urandom_range(0, NR - 1), 8'($urandom));
            run_frame(-1, 0, $urandom_range(0, 3));
        end

        rst = 1'b1;
        #1;
        check_eq("final_rst_err", err, 0);
        check_eq("final_rst_det_rst", det_rst, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
